// File: rtl/sdram_channel_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared types and constants for the SDRAM channel arbiter.
//   ADDR_W / DATA_W : byte address and data widths of the channel
//   Q_IDLE          : read-data value presented after reset or a timed-out read
//   state_t         : arbiter FSM state encoding
//   cmd_t           : command latched from the winning requester
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int          ADDR_W = 27;
    localparam int          DATA_W = 8;
    localparam logic [7:0]  Q_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/sdram_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_channel_arbiter_if
//   Bundles the requester-side bus and the SDRAM device-port side of the
//   arbiter, plus the upload lock input and the sticky timeout flag.
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters + SDRAM channel)
// ---------------------------------------------------------------------------
interface sdram_channel_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    // requester side
    logic                             upload;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_rnw;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]               req_ack;
    logic [DATA_W-1:0]                req_q;
    logic [NUM_REQ-1:0]               grant;
    // SDRAM channel side
    logic [ADDR_W-1:0]                sdram_addr;
    logic [DATA_W-1:0]                sdram_data;
    logic                             sdram_rnw;
    logic                             sdram_cs;
    logic [DATA_W-1:0]                sdram_q;
    logic                             sdram_ready;
    logic                             sdram_done;
    // status
    logic                             timeout_err;

    modport slave (
        input  upload, req_valid, req_rnw, req_addr, req_data,
        input  sdram_q, sdram_ready, sdram_done,
        output req_ack, req_q, grant,
        output sdram_addr, sdram_data, sdram_rnw, sdram_cs,
        output timeout_err
    );

    modport master (
        output upload, req_valid, req_rnw, req_addr, req_data,
        output sdram_q, sdram_ready, sdram_done,
        input  req_ack, req_q, grant,
        input  sdram_addr, sdram_data, sdram_rnw, sdram_cs,
        input  timeout_err
    );

endinterface

// File: rtl/sdram_channel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: finds the first set bit of elig at or
//   after ptr, wrapping past N-1 back to 0.
//   elig : eligible requesters
//   ptr  : highest-priority index for this pick (must be < N)
//   gnt  : one-hot winner, 0 when nothing is eligible
//   idx  : binary index of the winner
//   any  : at least one requester eligible
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!any && elig[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sdram_channel_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_channel_arbiter
//   Shares one SDRAM channel between NUM_REQ byte requesters
//   (0 = MSX, 1 = upload, 2 = flash, 3 = backup). Every access runs
//   cs pulse -> wait for sdram_done -> one-cycle ack, with round-robin
//   fairness. While upload=1 only UPLOAD_IDX may win. A done-timeout forces
//   completion so a hung channel cannot stall the MSX.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : requester bus + SDRAM device port (see interface)
//   Parameters   : NUM_REQ, UPLOAD_IDX, TIMEOUT (0 disables the timeout)
// ---------------------------------------------------------------------------
module sdram_channel_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int UPLOAD_IDX = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      reset_n,
    sdram_channel_arbiter_if.slave    bus
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [TMO_W-1:0]   TMO_LAST    = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_REQ-1:0] UPLOAD_MASK = NUM_REQ'(1) << UPLOAD_IDX;
    localparam logic [IW-1:0]      LAST_IDX    = IW'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ISSUE   = ISSUE;
    localparam logic [1:0] S_WAIT    = WAIT_DONE;
    localparam logic [1:0] S_RESPOND = RESPOND;

    logic [1:0]          state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win_idx;
    cmd_t                cmd;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   q_q;
    logic                cs_q;
    logic                terr_q;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    // The upload mask is sampled only in IDLE, so toggling upload during a
    // transaction affects the next pick, never the one in flight.
    assign elig = bus.upload ? (bus.req_valid & UPLOAD_MASK) : bus.req_valid;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .elig (elig),
        .ptr  (rr_ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            cmd.rnw  <= 1'b1;
            cmd.addr <= '0;
            cmd.data <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            q_q      <= Q_IDLE;
            cs_q     <= 1'b0;
            terr_q   <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            cs_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.sdram_ready && pick_any) begin
                        cmd.rnw  <= bus.req_rnw[pick_idx];
                        cmd.addr <= bus.req_addr[pick_idx];
                        cmd.data <= bus.req_data[pick_idx];
                        grant_q  <= pick_gnt;
                        win_idx  <= pick_idx;
                        cs_q     <= 1'b1;          // visible during ISSUE only
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A real done always beats a timeout landing in the same cycle.
                    if (bus.sdram_done) begin
                        if (cmd.rnw) q_q <= bus.sdram_q;
                        ack_q <= grant_q;
                        state <= S_RESPOND;
                    end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                        if (cmd.rnw) q_q <= Q_IDLE;
                        terr_q <= 1'b1;
                        ack_q  <= grant_q;
                        state  <= S_RESPOND;
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESPOND: begin
                    // Ack is high for exactly this state; the owner moves to
                    // the back of the round-robin order.
                    ack_q   <= '0;
                    grant_q <= '0;
                    rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.req_q       = q_q;
    assign bus.grant       = grant_q;
    assign bus.sdram_addr  = cmd.addr;
    assign bus.sdram_data  = cmd.data;
    assign bus.sdram_rnw   = cmd.rnw;
    assign bus.sdram_cs    = cs_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_channel_arbiter.sv
module tb_sdram_channel_arbiter;
    import sdram_arb_pkg::*;

    localparam int NR  = 4;
    localparam int UP  = 1;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset_n;

    int vectors     = 0;
    int miscompares = 0;

    // SDRAM behaviour knobs
    int done_delay = 3;
    bit hang       = 1'b0;

    // reference model state
    int         m_rr   = 0;
    logic [7:0] m_q    = 8'hFF;
    bit         m_terr = 1'b0;

    sdram_channel_arbiter_if #(.NUM_REQ(NR)) bus();

    sdram_channel_arbiter #(
        .NUM_REQ    (NR),
        .UPLOAD_IDX (UP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // SDRAM contents: a fixed function of the address
    function automatic logic [7:0] rd_data(input logic [26:0] a);
        return 8'h5A ^ a[7:0] ^ a[15:8];
    endfunction

    // SDRAM channel: done pulses done_delay cycles after the cs cycle
    initial begin
        bit         pend;
        int         cnt;
        logic       r_rnw;
        logic [26:0] r_addr;
        pend = 1'b0; cnt = 0; r_rnw = 1'b1; r_addr = '0;
        bus.sdram_done = 1'b0;
        bus.sdram_q    = 8'h00;
        forever begin
            @(negedge clk);
            bus.sdram_done = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        bus.sdram_done = 1'b1;
                        bus.sdram_q = r_rnw ? rd_data(r_addr) : 8'hC3;
                    end
                end
                if (bus.sdram_cs && !hang) begin
                    pend   = 1'b1;
                    cnt    = done_delay;
                    r_rnw  = bus.sdram_rnw;
                    r_addr = bus.sdram_addr;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_ack"},   32'(bus.req_ack), 32'd0);
        check({tag, "_cs"},    32'(bus.sdram_cs), 32'd0);
        check({tag, "_addr"},  32'(bus.sdram_addr), 32'd0);
        check({tag, "_data"},  32'(bus.sdram_data), 32'd0);
        check({tag, "_rnw"},   32'(bus.sdram_rnw), 32'd1);
        check({tag, "_q"},     32'(bus.req_q), 32'hFF);
        check({tag, "_terr"},  32'(bus.timeout_err), 32'd0);
    endtask

    task automatic arm(input int i, input logic rnw, input logic [26:0] a, input logic [7:0] d);
        bus.req_rnw[i]   = rnw;
        bus.req_addr[i]  = a;
        bus.req_data[i]  = d;
        bus.req_valid[i] = 1'b1;
    endtask

    // Serve one transaction; called at a negedge while the arbiter is idle.
    task automatic serve_one(input bit drop_early, output int wait_cyc, output int who);
        int          w, k, lat, cs_extra;
        logic [NR-1:0] el;
        logic        e_rnw;
        logic [26:0] e_a;
        logic [7:0]  e_d;
        bit          tmo_exp;
        el = bus.req_valid;
        if (bus.upload)
            for (int i = 0; i < NR; i++) if (i != UP) el[i] = 1'b0;
        w = -1;
        for (int i = 0; i < NR; i++) begin
            k = (m_rr + i) % NR;
            if (w < 0 && el[k]) w = k;
        end
        if (w < 0) w = 0;
        who   = w;
        e_rnw = bus.req_rnw[w];
        e_a   = bus.req_addr[w];
        e_d   = bus.req_data[w];

        wait_cyc = 0;
        while (bus.grant == '0 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("grant",      32'(bus.grant), 32'(1) << w);
        check("cs_issue",   32'(bus.sdram_cs), 32'd1);
        check("sdram_addr", 32'(bus.sdram_addr), 32'(e_a));
        check("sdram_data", 32'(bus.sdram_data), 32'(e_d));
        check("sdram_rnw",  32'(bus.sdram_rnw), 32'(e_rnw));
        if (drop_early) bus.req_valid[w] = 1'b0;
        tmo_exp = hang;

        lat = 0; cs_extra = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.sdram_cs) cs_extra++;
        end while (bus.req_ack == '0 && lat < 200);
        check("ack_latency", 32'(lat), tmo_exp ? 32'(TMO + 1) : 32'(done_delay + 1));
        check("ack_onehot",  32'(bus.req_ack), 32'(1) << w);
        check("single_cs",   32'(cs_extra), 32'd0);
        if (e_rnw) m_q = tmo_exp ? 8'hFF : rd_data(e_a);
        m_terr = m_terr | tmo_exp;
        check("req_q",       32'(bus.req_q), 32'(m_q));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        bus.req_valid[w] = 1'b0;
        m_rr = (w + 1) % NR;

        @(negedge clk);
        check("ack_cleared",   32'(bus.req_ack), 32'd0);
        check("grant_cleared", 32'(bus.grant), 32'd0);
    endtask

    initial begin
        int wc, who, cnt;
        bus.upload      = 1'b0;
        bus.req_valid   = '0;
        bus.req_rnw     = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.sdram_ready = 1'b1;
        reset_n         = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // contention from reset: served 0,1,2,3
        for (int i = 0; i < NR; i++) arm(i, 1'b0, 27'(32'h100 + i), 8'(8'h10 + i));
        for (int n = 0; n < NR; n++) begin
            serve_one(1'b0, wc, who);
            check("rr_order", 32'(who), 32'(n));
        end

        // single read
        done_delay = 3;
        arm(0, 1'b1, 27'h40000, 8'h00);
        serve_one(1'b0, wc, who);
        check("single_read_q", 32'(bus.req_q), 32'h5A);

        // upload lock
        bus.upload = 1'b1;
        arm(0, 1'b1, 27'h00777, 8'h00);
        arm(1, 1'b0, 27'h01000, 8'hA0);
        for (int n = 0; n < 3; n++) begin
            serve_one(1'b0, wc, who);
            check("upload_only", 32'(who), 32'(UP));
            arm(1, 1'b0, 27'(32'h01001 + n), 8'(8'hA1 + n));
        end
        bus.upload = 1'b0;
        serve_one(1'b0, wc, who);
        check("after_upload", 32'(who), 32'd0);
        serve_one(1'b0, wc, who);
        check("upload_req_left", 32'(who), 32'(UP));

        // timeout, then stickiness
        hang = 1'b1;
        arm(2, 1'b1, 27'h01234, 8'h00);
        serve_one(1'b0, wc, who);
        hang = 1'b0;
        arm(2, 1'b0, 27'h01235, 8'h99);
        serve_one(1'b0, wc, who);

        // ready gating
        bus.sdram_ready = 1'b0;
        arm(2, 1'b0, 27'h02222, 8'h77);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sdram_cs || bus.grant != '0) cnt++;
        end
        check("ready_gate", 32'(cnt), 32'd0);
        bus.sdram_ready = 1'b1;
        serve_one(1'b0, wc, who);
        check("ready_rise_cs", 32'(wc), 32'd1);

        // async reset in WAIT_DONE
        done_delay = 5;
        arm(3, 1'b1, 27'h05555, 8'h00);
        cnt = 0;
        while (!bus.sdram_cs && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_cs", 32'(bus.sdram_cs), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.req_ack != '0) cnt++;
        end
        check("no_ack_in_reset", 32'(cnt), 32'd0);
        m_rr = 0; m_q = 8'hFF; m_terr = 1'b0;
        reset_n = 1'b1;
        serve_one(1'b0, wc, who);
        check("post_reset_who", 32'(who), 32'd3);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
                    arm(i, 1'($urandom_range(0, 1)), 27'($urandom), 8'($urandom));
            if (bus.req_valid == '0)
                arm(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)), 27'($urandom), 8'($urandom));
            done_delay = int'($urandom_range(1, 5));
            cnt = int'($urandom_range(0, 3));
            if (cnt > 0) begin
                bus.sdram_ready = 1'b0;
                repeat (cnt) @(negedge clk);
                check("rnd_ready_hold", 32'(bus.grant), 32'd0);
                bus.sdram_ready = 1'b1;
            end
            serve_one($urandom_range(0, 3) == 0, wc, who);
        end
        bus.req_valid = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
